// File: rtl/tlul_host_arb.sv
// Two-host TL-UL arbiter in front of a single shared device, with in-order response routing.
// Define TLUL_HOST_ARB_RR_EN for round-robin arbitration; the default build uses fixed priority to host 0.
`timescale 1ns/1ps

package tlul_pkg;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

// state       | meaning
// ARB_FREE    | no request held, winner picked fresh this cycle
// ARB_LOCK_H0 | host 0 presented a_valid without handshake, grant held
// ARB_LOCK_H1 | host 1 presented a_valid without handshake, grant held
module tlul_host_arb
    import tlul_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic    clk_i,
    input  logic    rst_ni,
    input  tl_h2d_t tl_h0_i,
    output tl_d2h_t tl_h0_o,
    input  tl_h2d_t tl_h1_i,
    output tl_d2h_t tl_h1_o,
    output tl_h2d_t tl_d_o,
    input  tl_d2h_t tl_d_i,
    output logic    spurious_rsp_o
);

    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(MaxOutstanding - 1);
    localparam logic [CntW-1:0] CntFull = CntW'(MaxOutstanding);

    typedef enum logic [1:0] {
        ARB_FREE    = 2'd0,
        ARB_LOCK_H0 = 2'd1,
        ARB_LOCK_H1 = 2'd2
    } arb_state_e;

    arb_state_e state_q, state_d;

    logic [MaxOutstanding-1:0] id_mem;
    logic [PtrW-1:0]           wr_ptr, rd_ptr;
    logic [CntW-1:0]           count;

    logic full, empty, head_host;
    logic pick, grant, req_valid, dev_a_valid, a_ok;
    logic a_fire, d_fire, dev_d_ready;

    assign full      = (count == CntFull);
    assign empty     = (count == '0);
    assign head_host = id_mem[rd_ptr];

`ifdef TLUL_HOST_ARB_RR_EN
    logic prio_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q <= 1'b0;
        end else if (a_fire) begin
            prio_q <= ~grant;
        end
    end

    assign pick = tl_h1_i.a_valid & (~tl_h0_i.a_valid | prio_q);
`else
    assign pick = tl_h1_i.a_valid & ~tl_h0_i.a_valid;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ARB_FREE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        grant   = pick;
        state_d = ARB_FREE;
        unique case (state_q)
            ARB_LOCK_H0: grant = 1'b0;
            ARB_LOCK_H1: grant = 1'b1;
            default:     grant = pick;
        endcase
        req_valid   = grant ? tl_h1_i.a_valid : tl_h0_i.a_valid;
        // Reset gating keeps the device request quiet while rst_ni is held low.
        dev_a_valid = req_valid & ~full & rst_ni;
        a_fire      = dev_a_valid & tl_d_i.a_ready;
        if (dev_a_valid && !tl_d_i.a_ready) begin
            state_d = grant ? ARB_LOCK_H1 : ARB_LOCK_H0;
        end
    end

    assign a_ok        = tl_d_i.a_ready & ~full;
    assign dev_d_ready = empty ? 1'b1 : (head_host ? tl_h1_i.d_ready : tl_h0_i.d_ready);
    assign d_fire      = tl_d_i.d_valid & ~empty & dev_d_ready;

    always_comb begin
        tl_d_o         = grant ? tl_h1_i : tl_h0_i;
        tl_d_o.a_valid = dev_a_valid;
        tl_d_o.d_ready = dev_d_ready;

        tl_h0_o         = tl_d_i;
        tl_h0_o.a_ready = ~grant & a_ok;
        tl_h0_o.d_valid = tl_d_i.d_valid & ~empty & ~head_host;

        tl_h1_o         = tl_d_i;
        tl_h1_o.a_ready = grant & a_ok;
        tl_h1_o.d_valid = tl_d_i.d_valid & ~empty & head_host;
    end

    assign spurious_rsp_o = tl_d_i.d_valid & empty & rst_ni;

    // Response-routing FIFO: one host ID per accepted request, popped in order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            id_mem <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (a_fire) begin
                id_mem[wr_ptr] <= grant;
                wr_ptr         <= (wr_ptr == PtrLast) ? '0 : wr_ptr + PtrW'(1);
            end
            if (d_fire) begin
                rd_ptr <= (rd_ptr == PtrLast) ? '0 : rd_ptr + PtrW'(1);
            end
            unique case ({a_fire, d_fire})
                2'b10:   count <= count + CntW'(1);
                2'b01:   count <= count - CntW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_tlul_host_arb.sv
// Bench for tlul_host_arb: fixed vector table, directed corner sequences, and random traffic
// checked against a queue-based reference model.
`timescale 1ns/1ps

module tb_tlul_host_arb;
    import tlul_pkg::*;

    localparam int MAXO = 2;
`ifdef TLUL_HOST_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic    clk_i = 1'b0;
    logic    rst_ni = 1'b0;
    tl_h2d_t tl_h0_i, tl_h1_i, tl_d_o;
    tl_d2h_t tl_h0_o, tl_h1_o, tl_d_i;
    logic    spurious_rsp_o;

    int checks = 0;
    int errors = 0;

    tlul_host_arb #(.MaxOutstanding(MAXO)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .tl_h0_i        (tl_h0_i),
        .tl_h0_o        (tl_h0_o),
        .tl_h1_i        (tl_h1_i),
        .tl_h1_o        (tl_h1_o),
        .tl_d_o         (tl_d_o),
        .tl_d_i         (tl_d_i),
        .spurious_rsp_o (spurious_rsp_o)
    );

    always #5 clk_i = ~clk_i;

    // stim = {h0v, h1v, dev_a_ready, d_valid, h0_d_ready, h1_d_ready}
    // exp  = {dev_a_valid, h0_a_ready, h1_a_ready, h0_d_valid, h1_d_valid, dev_d_ready, spurious}
    typedef struct {
        logic [5:0]  stim;
        logic [31:0] ddata;
        logic [6:0]  exp;
        logic [7:0]  src;
    } vec_t;

    vec_t vecs[9];

    // reference model state
    int   q[$];
    int   lock_h;
    int   prio;
    int   e_grant;
    logic e_av, e_ar0, e_ar1, e_dv0, e_dv1, e_dr, e_spur, e_push, e_pop;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [6:0] obs();
        return {tl_d_o.a_valid, tl_h0_o.a_ready, tl_h1_o.a_ready,
                tl_h0_o.d_valid, tl_h1_o.d_valid, tl_d_o.d_ready, spurious_rsp_o};
    endfunction

    // a_ready of a host that is not requesting carries no meaning
    function automatic logic [6:0] obs_mask();
        return {1'b1, tl_h0_i.a_valid, tl_h1_i.a_valid, 4'b1111};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_in(input logic [5:0] s, input logic [31:0] dd);
        tl_h0_i.a_valid  = s[5];
        tl_h1_i.a_valid  = s[4];
        tl_d_i.a_ready   = s[3];
        tl_d_i.d_valid   = s[2];
        tl_h0_i.d_ready  = s[1];
        tl_h1_i.d_ready  = s[0];
        tl_d_i.d_data    = dd;
    endtask

    task automatic fixed_payload();
        tl_h0_i = '0;
        tl_h1_i = '0;
        tl_d_i  = '0;
        tl_h0_i.a_source  = 8'h10;
        tl_h0_i.a_address = 32'h1000_0000;
        tl_h1_i.a_source  = 8'h21;
        tl_h1_i.a_address = 32'h2000_0000;
    endtask

    task automatic do_reset();
        fixed_payload();
        rst_ni = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
        q.delete();
        lock_h = -1;
        prio   = 0;
    endtask

    task automatic rand_req(inout tl_h2d_t p);
        p.a_opcode  = 3'($urandom_range(0, 4));
        p.a_param   = 3'($urandom_range(0, 7));
        p.a_size    = 2'($urandom_range(0, 2));
        p.a_source  = 8'($urandom());
        p.a_address = $urandom();
        p.a_mask    = 4'($urandom());
        p.a_data    = $urandom();
    endtask

    task automatic model_eval();
        bit full, empty;
        int head;
        logic h0v, h1v, req;
        h0v   = tl_h0_i.a_valid;
        h1v   = tl_h1_i.a_valid;
        full  = (q.size() == MAXO);
        empty = (q.size() == 0);
        head  = empty ? 0 : q[0];
        if (lock_h >= 0)      e_grant = lock_h;
        else if (h0v && h1v)  e_grant = RR ? prio : 0;
        else if (h1v)         e_grant = 1;
        else                  e_grant = 0;
        req    = (e_grant == 1) ? h1v : h0v;
        e_av   = req && !full;
        e_ar0  = (e_grant == 0) && tl_d_i.a_ready && !full;
        e_ar1  = (e_grant == 1) && tl_d_i.a_ready && !full;
        e_dv0  = tl_d_i.d_valid && !empty && head == 0;
        e_dv1  = tl_d_i.d_valid && !empty && head == 1;
        e_dr   = empty ? 1'b1 : (head == 1 ? tl_h1_i.d_ready : tl_h0_i.d_ready);
        e_spur = tl_d_i.d_valid && empty;
        e_push = e_av && tl_d_i.a_ready;
        e_pop  = tl_d_i.d_valid && !empty && e_dr;
    endtask

    task automatic model_commit();
        if (e_pop) void'(q.pop_front());
        if (e_push) begin
            q.push_back(e_grant);
            prio = 1 - e_grant;
        end
        lock_h = (e_av && !tl_d_i.a_ready) ? e_grant : -1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [6:0] m;
        logic [7:0] exp_src[4];
        tl_h2d_t    g, e;
        bit         pend0, pend1;

        vecs[0] = '{6'b10_1_0_11, 32'h0, 7'b1_10_00_1_0, 8'h10};
        vecs[1] = '{6'b01_1_0_11, 32'h0, 7'b1_01_00_1_0, 8'h21};
        vecs[2] = '{6'b11_1_0_01, 32'h0, 7'b0_00_00_0_0, 8'h00};
        vecs[3] = '{6'b11_1_1_11, 32'hA, 7'b0_00_10_1_0, 8'h00};
        vecs[4] = '{6'b10_1_0_00, 32'h0, 7'b1_10_00_0_0, 8'h10};
        vecs[5] = '{6'b00_0_1_01, 32'hB, 7'b0_00_01_1_0, 8'h00};
        vecs[6] = '{6'b00_0_1_10, 32'hC, 7'b0_00_10_1_0, 8'h00};
        vecs[7] = '{6'b00_0_1_00, 32'hD, 7'b0_00_00_1_1, 8'h00};
        vecs[8] = '{6'b00_0_0_00, 32'h0, 7'b0_00_00_1_0, 8'h00};

        // reset values while rst_ni is low, with a request and a response pending
        fixed_payload();
        set_in(6'b11_1_1_11, 32'h5);
        #2;
        chk("reset_outputs", 128'(obs() & 7'b1_00_11_0_1), 128'(7'b0));

        do_reset();

        for (int i = 0; i < 9; i++) begin
            set_in(vecs[i].stim, vecs[i].ddata);
            #2;
            m = obs_mask();
            chk($sformatf("vec%0d_ctrl", i), 128'(obs() & m), 128'(vecs[i].exp & m));
            if (vecs[i].exp[6]) chk($sformatf("vec%0d_src", i), 128'(tl_d_o.a_source), 128'(vecs[i].src));
            chk($sformatf("vec%0d_ddata", i), 128'({tl_h0_o.d_data, tl_h1_o.d_data}),
                128'({vecs[i].ddata, vecs[i].ddata}));
            tick();
        end

        // both hosts contending with a ready device
        do_reset();
        exp_src[0] = 8'h10;
        exp_src[1] = RR ? 8'h21 : 8'h10;
        exp_src[2] = 8'h10;
        exp_src[3] = RR ? 8'h21 : 8'h10;
        for (int i = 0; i < 4; i++) begin
            set_in((i == 0) ? 6'b11_1_0_11 : 6'b11_1_1_11, 32'h0);
            #2;
            chk($sformatf("alt%0d_src", i), 128'({tl_d_o.a_valid, tl_d_o.a_source}), 128'({1'b1, exp_src[i]}));
            tick();
        end

        // grant held on host 1 across device back-pressure
        do_reset();
        set_in(6'b01_0_0_11, 32'h0);
        #2;
        chk("lock_c0", 128'({tl_d_o.a_valid, tl_d_o.a_source, tl_h1_o.a_ready}), 128'({1'b1, 8'h21, 1'b0}));
        tick();
        for (int i = 1; i < 3; i++) begin
            set_in(6'b11_0_0_11, 32'h0);
            #2;
            chk($sformatf("lock_c%0d", i), 128'({tl_d_o.a_source, tl_h0_o.a_ready, tl_h1_o.a_ready}),
                128'({8'h21, 1'b0, 1'b0}));
            tick();
        end
        set_in(6'b11_1_0_11, 32'h0);
        #2;
        chk("lock_hs", 128'({tl_d_o.a_source, tl_h0_o.a_ready, tl_h1_o.a_ready}), 128'({8'h21, 1'b0, 1'b1}));
        tick();
        set_in(6'b10_1_0_11, 32'h0);
        #2;
        chk("lock_after", 128'({tl_d_o.a_valid, tl_d_o.a_source, tl_h0_o.a_ready}), 128'({1'b1, 8'h10, 1'b1}));
        tick();

        // reset with two outstanding requests from host 0
        do_reset();
        set_in(6'b10_1_0_11, 32'h0);
        tick();
        tick();
        set_in(6'b10_1_0_11, 32'h0);
        #2;
        chk("full_before_rst", 128'({tl_d_o.a_valid, tl_h0_o.a_ready}), 128'(2'b00));
        rst_ni = 1'b0;
        set_in(6'b11_1_1_11, 32'h7);
        #1;
        chk("in_rst", 128'(obs() & 7'b1_00_11_0_1), 128'(7'b0));
        tick();
        rst_ni = 1'b1;
        set_in(6'b00_0_1_11, 32'h9);
        #2;
        chk("post_rst_spur", 128'(obs() & 7'b1_00_11_1_1), 128'(7'b0_00_00_1_1));
        tick();
        set_in(6'b00_0_0_11, 32'h0);
        #2;
        chk("spur_one_cycle", 128'(spurious_rsp_o), 128'(1'b0));
        tick();
        set_in(6'b11_1_0_11, 32'h0);
        #2;
        chk("post_rst_prio", 128'({tl_d_o.a_valid, tl_d_o.a_source}), 128'({1'b1, 8'h10}));
        tick();

        // random traffic against the reference model
        do_reset();
        pend0 = 1'b0;
        pend1 = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (!pend0) begin
                tl_h0_i.a_valid = ($urandom_range(0, 99) < 60);
                rand_req(tl_h0_i);
            end
            if (!pend1) begin
                tl_h1_i.a_valid = ($urandom_range(0, 99) < 60);
                rand_req(tl_h1_i);
            end
            tl_d_i.a_ready   = ($urandom_range(0, 99) < 70);
            tl_d_i.d_valid   = ($urandom_range(0, 99) < 45);
            tl_d_i.d_data    = $urandom();
            tl_d_i.d_source  = 8'($urandom());
            tl_d_i.d_error   = 1'($urandom());
            tl_h0_i.d_ready  = ($urandom_range(0, 99) < 80);
            tl_h1_i.d_ready  = ($urandom_range(0, 99) < 80);
            #2;
            model_eval();
            m = obs_mask();
            chk($sformatf("rnd%0d_ctrl", c), 128'(obs() & m),
                128'({e_av, e_ar0, e_ar1, e_dv0, e_dv1, e_dr, e_spur} & m));
            if (e_av) begin
                g = tl_d_o;
                e = (e_grant == 1) ? tl_h1_i : tl_h0_i;
                g.a_valid = 1'b0;
                g.d_ready = 1'b0;
                e.a_valid = 1'b0;
                e.d_ready = 1'b0;
                chk($sformatf("rnd%0d_fwd", c), 128'(g), 128'(e));
            end
            if (c % 16 == 0) begin
                chk($sformatf("rnd%0d_dfields", c), 128'({tl_h0_o.d_data, tl_h1_o.d_source, tl_h1_o.d_error}),
                    128'({tl_d_i.d_data, tl_d_i.d_source, tl_d_i.d_error}));
            end
            model_commit();
            pend0 = tl_h0_i.a_valid && !(e_push && e_grant == 0);
            pend1 = tl_h1_i.a_valid && !(e_push && e_grant == 1);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tlul_host_arb.md
TLUL_HOST_ARB -- requirements
Module: tlul_host_arb

Interface
REQ-001 SHALL have parameter MaxOutstanding, default 2, meaning response-routing FIFO depth (1..8).
REQ-002 SHALL have port clk_i, input, 1, the single clock.
REQ-003 SHALL have port rst_ni, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port tl_h0_i, input, tl_h2d_t, host 0 request (instruction fetch).
REQ-005 SHALL have port tl_h0_o, output, tl_d2h_t, host 0 response.
REQ-006 SHALL have port tl_h1_i, input, tl_h2d_t, host 1 request (LSU).
REQ-007 SHALL have port tl_h1_o, output, tl_d2h_t, host 1 response.
REQ-008 SHALL have port tl_d_o, output, tl_h2d_t, request to the shared device (ICCM).
REQ-009 SHALL have port tl_d_i, input, tl_d2h_t, response from the shared device.
REQ-010 SHALL have port spurious_rsp_o, output, 1, one-cycle pulse when a device response arrives with no outstanding request.

Function
REQ-011 SHALL arbitrate A-channel each cycle between hosts with a_valid=1; the winner's tl_h2d_t is forwarded combinationally to tl_d_o (zero latency).
REQ-012 SHALL lock the grant while tl_d_o.a_valid=1 and the A handshake has not completed; the lock releases in the cycle after the handshake.
REQ-013 SHALL drive tl_d_o.a_valid=0 while the FIFO holds MaxOutstanding entries; both hosts then see a_ready=0.
REQ-014 SHALL drive granted host a_ready = tl_d_i.a_ready AND NOT full; the non-granted host SHALL see a_ready=0.
REQ-015 SHALL push the granted host ID into the FIFO on each device A handshake (tl_d_o.a_valid & tl_d_i.a_ready).
REQ-016 SHALL route tl_d_i.d_valid only to the host at the FIFO head; the other host SHALL see d_valid=0; all other D fields go to both hosts unchanged.
REQ-017 SHALL drive tl_d_o.d_ready from the head host's d_ready and pop on tl_d_i.d_valid & tl_d_o.d_ready.
REQ-018 SHALL leave the count unchanged on a simultaneous push and pop; a push when full SHALL be impossible (REQ-013); the FIFO pointers SHALL wrap modulo MaxOutstanding.
REQ-019 SHALL, with the FIFO empty and tl_d_i.d_valid=1, drive tl_d_o.d_ready=1, deliver to no host, and pulse spurious_rsp_o for that cycle.
REQ-020 SHALL pass a_source and all A fields unmodified; request ordering per device SHALL be preserved.
REQ-021 SHALL drive tl_d_o.a_valid=0 when neither host requests; the A payload is then don't-care.

Reset
REQ-022 SHALL on rst_ni=0 asynchronously clear the FIFO (count 0, pointers 0), clear the grant lock, and set the priority pointer to host 0.
REQ-023 SHALL hold all outputs at reset as follows: tl_d_o.a_valid=0, tl_h0_o.d_valid=0, tl_h1_o.d_valid=0, spurious_rsp_o=0.
REQ-024 SHALL discard outstanding entries on reset mid-operation; responses after reset SHALL be treated per REQ-019.

Configuration
REQ-025 SHALL, with TLUL_HOST_ARB_RR_EN defined, use round-robin arbitration: after each accepted A handshake, priority moves to the other host.
REQ-026 SHALL, without TLUL_HOST_ARB_RR_EN, use fixed priority, with host 0 winning whenever the grant is unlocked; the priority pointer is then unused.

Verification
REQ-027 SHALL cover: both hosts valid, device a_ready=1, RR enabled -> grants alternate h0,h1,h0,h1 over 4 cycles; fixed priority -> h0 for all 4.
REQ-028 SHALL cover: h1 granted, device a_ready=0 for 3 cycles, h0 raises a_valid -> h1 stays granted until its handshake, then h0.
REQ-029 SHALL cover: MaxOutstanding=2, two accepted requests with no response -> a_ready=0 to both; one response popped -> next request accepted in the following cycle.
REQ-030 SHALL cover: requests h0 then h1 accepted; device returns d_data 0xA then 0xB -> h0 receives 0xA and h1 receives 0xB; neither host sees the other's d_valid.
REQ-031 SHALL cover: d_valid with FIFO empty -> spurious_rsp_o=1 for one cycle, no host d_valid, d_ready=1.
REQ-032 SHALL cover: rst_ni low with 2 outstanding -> count 0 and priority host 0; the next device response flagged spurious.
